// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one registered adder across requesters
// Tags each issued operation and returns sums in issue order through a response FIFO.

module adder_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int ADD_LAT   = 1,
  parameter int RSP_DEPTH = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         add_a_o,
  output logic [DATA_W-1:0]         add_b_o,
  input  logic [DATA_W:0]           add_sum_i,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_win;
  logic              w_any;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  logic [ADD_LAT-1:0] r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [ADD_LAT];

  logic [ID_W-1:0]   r_mem_id  [RSP_DEPTH];
  logic [DATA_W:0]   r_mem_sum [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  w_out_nxt;
  logic              r_busy;

  // Rotating scan: first valid requester after the last winner takes the slot.
  always_comb begin : p_grant
    logic [ID_W-1:0] idx;
    w_any = 1'b0;
    w_win = '0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(r_last_grant) + off) % NUM_REQ);
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  // Credits count tag-pipe plus FIFO occupancy, so a push always finds room.
  assign w_issue = !rst && w_any && (r_outstanding < CNT_W'(RSP_DEPTH));

  always_comb begin
    req_ready = '0;
    add_a_o   = '0;
    add_b_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_issue && (w_win == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        add_a_o      = req_a[i*DATA_W +: DATA_W];
        add_b_o      = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (w_issue) begin
      r_last_grant <= w_win;
    end
  end

  // The last tag stage lines up with the cycle the adder presents the matching sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_win;
      for (int i = 1; i < ADD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign w_push    = !rst && r_tag_vld[ADD_LAT-1];
  assign rsp_valid = !rst && (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]  <= r_tag_id[ADD_LAT-1];
      r_mem_sum[r_wr_ptr] <= add_sum_i;
    end
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_issue && !w_pop) begin
      w_out_nxt = r_outstanding + CNT_W'(1);
    end else if (!w_issue && w_pop) begin
      w_out_nxt = r_outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count       <= w_cnt_nxt;
      r_outstanding <= w_out_nxt;
      r_busy        <= (w_out_nxt != '0);
    end
  end

  assign rsp_id  = rsp_valid ? r_mem_id[r_rd_ptr]  : '0;
  assign rsp_sum = rsp_valid ? r_mem_sum[r_rd_ptr] : '0;
  assign busy_o  = !rst && r_busy;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - scoreboard bench for adder_rr_arbiter with a behavioural reference model
// Drives random and directed traffic; a monitor pops expected responses and compares them.

module tb_adder_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [W-1:0]     add_a_o;
  logic [W-1:0]     add_b_o;
  logic [W:0]       add_sum;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [W:0]       rsp_sum;
  logic             busy_o;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_sum_i(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy_o(busy_o)
  );

  // Registered adder with LAT stages.
  logic [W:0] add_pipe [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) add_pipe[i] <= '0;
    end else begin
      add_pipe[0] <= {1'b0, add_a_o} + {1'b0, add_b_o};
      for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign add_sum = add_pipe[LAT-1];

  typedef struct {int id; int sum; int rdy_cyc;} exp_t;
  typedef struct {int id; int sum;} pop_t;

  exp_t       sb[$];
  pop_t       pop_log[$];
  int         hs_log[$];
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  int checks = 0;
  int errors = 0;
  int last_g = N - 1;
  int issued = 0;
  int popped = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", int'(rsp_id), -1);
      end else begin
        e = sb.pop_front();
        check("pop_id", int'(rsp_id), e.id);
        check("pop_sum", int'(rsp_sum), e.sum);
        popped++;
      end
      pop_log.push_back('{int'(rsp_id), int'(rsp_sum)});
    end
  end

  task automatic step(input logic [N-1:0] v, input logic rr, input logic r);
    int win;
    int idx;
    int exp_rdy;
    int exp_a;
    int exp_b;
    bit exp_v;
    @(posedge clk);
    #1;
    rst       = r;
    rsp_ready = rr;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    #3;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && v[i]) hs_log.push_back(i);
    end
    if (r) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_add_a", int'(add_a_o), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_busy", int'(busy_o), 0);
      sb.delete();
      issued = 0;
      popped = 0;
      last_g = N - 1;
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].rdy_cyc <= cyc);
      check("rsp_valid", int'(rsp_valid), int'(exp_v));
      if (exp_v) begin
        check("head_id", int'(rsp_id), sb[0].id);
        check("head_sum", int'(rsp_sum), sb[0].sum);
      end else begin
        check("idle_rsp_sum", int'(rsp_sum), 0);
      end
      check("busy", int'(busy_o), int'((issued - popped) != 0));
      win = -1;
      if ((issued - popped) < DEPTH) begin
        for (int off = 1; off <= N; off++) begin
          idx = (last_g + off) % N;
          if (win < 0 && v[idx]) win = idx;
        end
      end
      exp_rdy = (win >= 0) ? (1 << win) : 0;
      exp_a   = (win >= 0) ? int'(op_a[win]) : 0;
      exp_b   = (win >= 0) ? int'(op_b[win]) : 0;
      check("req_ready", int'(req_ready), exp_rdy);
      check("add_a", int'(add_a_o), exp_a);
      check("add_b", int'(add_b_o), exp_b);
      if (win >= 0) begin
        sb.push_back('{win, exp_a + exp_b, cyc + LAT + 1});
        issued++;
        last_g = win;
        op_a[win] = W'($urandom);
        op_b[win] = W'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b1, 1'b0);
  endtask

  task automatic clear_logs();
    hs_log.delete();
    pop_log.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'($urandom);
      op_b[i] = W'($urandom);
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    idle(2);

    // Single request 200 + 100.
    op_a[0] = 8'd200;
    op_b[0] = 8'd100;
    clear_logs();
    step(4'b0001, 1'b1, 1'b0);
    check("single_hs_count", hs_log.size(), 1);
    idle(4);
    check("single_pops", pop_log.size(), 1);
    if (pop_log.size() > 0) begin
      check("single_id", pop_log[0].id, 0);
      check("single_sum", pop_log[0].sum, 300);
    end
    check("single_busy_end", int'(busy_o), 0);

    // Full contention.
    step('0, 1'b1, 1'b1);
    clear_logs();
    repeat (12) step(4'b1111, 1'b1, 1'b0);
    check("cont_hs_count", hs_log.size(), 12);
    for (int i = 0; i < hs_log.size(); i++) check("cont_grant", hs_log[i], i % 4);
    idle(4);
    check("cont_pops", pop_log.size(), 12);
    for (int i = 0; i < pop_log.size(); i++) check("cont_rsp_id", pop_log[i].id, i % 4);

    // Backpressure: exactly DEPTH acceptances, then in-order drain.
    step('0, 1'b1, 1'b1);
    clear_logs();
    repeat (8) step(4'b1111, 1'b0, 1'b0);
    check("bp_hs_count", hs_log.size(), DEPTH);
    for (int i = 0; i < hs_log.size(); i++) check("bp_grant", hs_log[i], i);
    check("bp_ready_low", int'(req_ready), 0);
    hs_log.delete();
    repeat (8) step(4'b1111, 1'b1, 1'b0);
    check("bp_drain_ge4", int'(pop_log.size() >= 4), 1);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) check("bp_drain_id", pop_log[i].id, i);
    check("bp_resume_nonempty", int'(hs_log.size() > 0), 1);
    if (hs_log.size() > 0) check("bp_resume_id", hs_log[0], 0);
    idle(6);

    // Fairness with skipped requesters.
    step('0, 1'b1, 1'b1);
    step(4'b0010, 1'b1, 1'b0);
    hs_log.delete();
    repeat (4) step(4'b1010, 1'b1, 1'b0);
    check("fair_hs_count", hs_log.size(), 4);
    for (int i = 0; i < hs_log.size(); i++) check("fair_grant", hs_log[i], (i % 2 == 0) ? 3 : 1);
    idle(5);

    // Maximum and zero operands.
    clear_logs();
    op_a[0] = 8'hFF;
    op_b[0] = 8'hFF;
    step(4'b0001, 1'b1, 1'b0);
    op_a[0] = 8'h00;
    op_b[0] = 8'h00;
    step(4'b0001, 1'b1, 1'b0);
    idle(4);
    check("max_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("max_sum", pop_log[0].sum, 510);
      check("zero_sum", pop_log[1].sum, 0);
    end

    // Reset while operations are in flight.
    clear_logs();
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    hs_log.delete();
    step(4'b1111, 1'b1, 1'b0);
    check("rst_mid_hs", hs_log.size(), 1);
    if (hs_log.size() > 0) check("rst_mid_grant", hs_log[0], 0);
    idle(5);
    check("rst_mid_pops", pop_log.size(), 1);
    if (pop_log.size() > 0) check("rst_mid_pop_id", pop_log[0].id, 0);

    // Randomized traffic with random backpressure.
    repeat (400) step(N'($urandom), logic'($urandom_range(0, 3) != 0), 1'b0);
    idle(10);
    check("final_sb_empty", sb.size(), 0);
    check("final_busy", int'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
